// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// legal oversampling ratios and the default frame width.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int OP_WIDTH_DEF = 8;

  // Anything outside the supported ratios falls back to the slowest-safe 8x.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter (0..prescale-1) and bit counter for uart_rx.
// Counting runs while cnt_en is high; both counters clear when it drops.
module edge_bit_counter #(
  parameter int BIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic [5:0]       prescale,
  output logic [5:0]       edge_cnt,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             edge_last
);

  logic [5:0]       edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign edge_last = (edge_cnt_q == prescale - 6'd1);
  assign edge_cnt  = edge_cnt_q;
  assign bit_cnt   = bit_cnt_q;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    edge_cnt_d = '0;
    bit_cnt_d  = '0;
    if (cnt_en) begin
      if (edge_last) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity and majority-vote sampling.
// Define UART_RX_STRT_CHK_EN to reject start bits that sample high (glitch filter).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic [5:0]          Prescale,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  output logic [OP_WIDTH-1:0] P_DATA,
  output logic                data_valid,
  output logic                par_err,
  output logic                stp_err
);

  localparam int BIT_W = $clog2(OP_WIDTH + 3);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(OP_WIDTH);

  state_e              state_q, state_d;
  logic [5:0]          prescale_q, prescale_d;
  logic                par_en_q, par_en_d;
  logic                par_typ_q, par_typ_d;
  logic                par_fail_q, par_fail_d;
  logic [2:0]          sample_q, sample_d;
  logic [OP_WIDTH-1:0] shift_q, shift_d;
  logic [OP_WIDTH-1:0] p_data_q, p_data_d;
  logic                data_valid_q, data_valid_d;
  logic                par_err_q, par_err_d;
  logic                stp_err_q, stp_err_d;

  logic [5:0]       edge_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             edge_last;
  logic [5:0]       mid;
  logic             in_window;
  logic             bit_val;

  edge_bit_counter #(.BIT_W(BIT_W)) u_cnt (
    .clk       (CLK),
    .rst_n     (RST),
    .cnt_en    (state_d != IDLE),
    .prescale  (prescale_q),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .edge_last (edge_last)
  );

  // Three samples around mid-bit; all are captured before the last edge count.
  assign mid       = prescale_q >> 1;
  assign in_window = (edge_cnt == mid - 6'd1) || (edge_cnt == mid) || (edge_cnt == mid + 6'd1);
  assign sample_d  = in_window ? {sample_q[1:0], RX_IN} : sample_q;
  assign bit_val   = (sample_q[0] & sample_q[1]) | (sample_q[0] & sample_q[2]) |
                     (sample_q[1] & sample_q[2]);

  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_fail_d   = par_fail_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d    = START;
          prescale_d = legal_prescale(Prescale);
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
        end
      end
      START: begin
        if (edge_last) begin
`ifdef UART_RX_STRT_CHK_EN
          state_d = bit_val ? IDLE : DATA;
`else
          state_d = DATA;
`endif
        end
      end
      DATA: begin
        if (edge_last) begin
          shift_d               = shift_q >> 1;
          shift_d[OP_WIDTH-1]   = bit_val;
          if (bit_cnt == LAST_DATA_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (edge_last) begin
          if (bit_val != ((^shift_q) ^ par_typ_q)) begin
            par_err_d  = 1'b1;
            par_fail_d = 1'b1;
          end
          state_d = STOP;
        end
      end
      STOP: begin
        if (edge_last) begin
          state_d = IDLE;
          if (!bit_val) begin
            stp_err_d = 1'b1;
          end else if (!par_fail_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      prescale_q   <= PRESCALE_8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      sample_q     <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_fail_q   <= par_fail_d;
      sample_q     <= sample_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model schedules expected pulses
// and P_DATA values by cycle; a per-cycle compare process checks the DUT.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;

  uart_rx #(.OP_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected events keyed by the cycle in which the output is visible.
  bit         exp_dv[int];
  bit         exp_pe[int];
  bit         exp_se[int];
  logic [7:0] pdata_at[int];
  logic [7:0] exp_pdata = 8'h00;

  int dv_q[$];
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      if (!RST) begin
        check("rst_p_data", 32'(P_DATA), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        check("rst_stp_err", 32'(stp_err), 32'h0);
      end else begin
        if (pdata_at.exists(cyc)) exp_pdata = pdata_at[cyc];
        check("data_valid", 32'(data_valid), 32'(exp_dv.exists(cyc)));
        check("par_err", 32'(par_err), 32'(exp_pe.exists(cyc)));
        check("stp_err", 32'(stp_err), 32'(exp_se.exists(cyc)));
        check("p_data", 32'(P_DATA), 32'(exp_pdata));
        if (data_valid) begin
          dv_q.push_back(cyc);
          dv_cnt++;
        end
        if (par_err) pe_cnt++;
        if (stp_err) se_cnt++;
      end
    end
  end

  function automatic int eff_p(input logic [5:0] p);
    return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  // Drives one frame bit-by-bit; rst_bit >= 0 aborts it with a reset mid-bit.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] pres, input bit pen,
                            input bit ptyp, input bit par_flip, input bit stop_val,
                            input bit noise, input bit scramble, input int rst_bit);
    int p;
    int nb;
    int t0;
    int tv;
    bit bits[11];
    p  = eff_p(pres);
    nb = pen ? 11 : 10;
    t0 = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (pen) begin
      bits[9]  = (^data) ^ ptyp ^ par_flip;
      bits[10] = stop_val;
    end else begin
      bits[9]  = stop_val;
      bits[10] = 1'b1;
    end
    for (int b = 0; b < nb; b++) begin
      int flip_pos;
      flip_pos = -1;
      if (noise && $urandom_range(1) == 1) flip_pos = p / 2 - 1 + int'($urandom_range(2));
      for (int e = 0; e < p; e++) begin
        @(posedge CLK); #1;
        if (b == 0 && e == 0) begin
          Prescale = pres;
          PAR_EN   = pen;
          PAR_TYP  = ptyp;
          t0 = cyc;
          if (rst_bit < 0) begin
            tv = t0 + nb * p;
            if (pen && par_flip) exp_pe[t0 + 10 * p] = 1'b1;
            if (!stop_val) exp_se[tv] = 1'b1;
            else if (!(pen && par_flip)) begin
              exp_dv[tv]   = 1'b1;
              pdata_at[tv] = data;
            end
          end
        end else if (scramble) begin
          Prescale = 6'($urandom);
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
        end
        RX_IN = (e == flip_pos) ? ~bits[b] : bits[b];
        if (b == rst_bit && e == p / 2) begin
          RST = 1'b0;
          RX_IN = 1'b1;
          exp_pdata = 8'h00;
          repeat (3) @(posedge CLK);
          #1;
          RST = 1'b1;
          return;
        end
      end
    end
  endtask

  // Two-cycle low pulse on an idle line at 16x oversampling.
  task automatic glitch();
    int t0;
    @(posedge CLK); #1;
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    RX_IN    = 1'b0;
    t0 = cyc;
`ifndef UART_RX_STRT_CHK_EN
    exp_dv[t0 + 160]   = 1'b1;
    pdata_at[t0 + 160] = 8'hFF;
`endif
    @(posedge CLK); #1;
    RX_IN = 1'b0;
    idle(170);
  endtask

  initial begin
    #200000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time bound expired");
  end

  initial begin
    int n0, p0, s0, nq;
    #2;
    RST = 1'b0;
    chk_on = 1'b1;
    #1;
    check("reset_p_data", 32'(P_DATA), 32'h0);
    check("reset_data_valid", 32'(data_valid), 32'h0);
    check("reset_par_err", 32'(par_err), 32'h0);
    check("reset_stp_err", 32'(stp_err), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(4);

    // 8x, no parity, 0xA5
    n0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    send_frame(8'hA5, 6'd8, 0, 0, 0, 1, 0, 0, -1);
    idle(3);
    check("a5_p_data", 32'(P_DATA), 32'hA5);
    check("a5_dv_count", 32'(dv_cnt - n0), 32'd1);
    check("a5_err_count", 32'((pe_cnt - p0) + (se_cnt - s0)), 32'd0);

    // 16x, even parity, good then bad parity
    n0 = dv_cnt;
    send_frame(8'h3C, 6'd16, 1, 0, 0, 1, 0, 0, -1);
    idle(3);
    check("3c_p_data", 32'(P_DATA), 32'h3C);
    check("3c_dv_count", 32'(dv_cnt - n0), 32'd1);
    n0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    send_frame(8'h3C, 6'd16, 1, 0, 1, 1, 0, 0, -1);
    idle(3);
    check("3c_bad_par_pe_count", 32'(pe_cnt - p0), 32'd1);
    check("3c_bad_par_dv_count", 32'(dv_cnt - n0), 32'd0);
    check("3c_bad_par_se_count", 32'(se_cnt - s0), 32'd0);
    check("3c_bad_par_p_data", 32'(P_DATA), 32'h3C);

    // 32x, odd parity, stop bit low
    n0 = dv_cnt; s0 = se_cnt;
    send_frame(8'h01, 6'd32, 1, 1, 0, 0, 0, 0, -1);
    idle(3);
    check("01_stop_se_count", 32'(se_cnt - s0), 32'd1);
    check("01_stop_dv_count", 32'(dv_cnt - n0), 32'd0);

    // start-bit glitch followed by a clean frame
    glitch();
    send_frame(8'h5A, 6'd16, 0, 0, 0, 1, 0, 0, -1);
    idle(3);
    check("5a_p_data", 32'(P_DATA), 32'h5A);

    // back-to-back 0xFF then 0x00 at 8x
    nq = dv_q.size();
    send_frame(8'hFF, 6'd8, 0, 0, 0, 1, 0, 0, -1);
    send_frame(8'h00, 6'd8, 0, 0, 0, 1, 0, 0, -1);
    idle(3);
    check("b2b_pulses", 32'(dv_q.size() - nq), 32'd2);
    if (dv_q.size() - nq == 2)
      check("b2b_spacing", 32'(dv_q[nq+1] - dv_q[nq]), 32'd80);
    check("b2b_p_data", 32'(P_DATA), 32'h00);

    // reset during data bit 4, then a full frame
    n0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    send_frame(8'h55, 6'd8, 0, 0, 0, 1, 0, 0, 5);
    idle(20);
    check("rst_abort_p_data", 32'(P_DATA), 32'h0);
    check("rst_abort_pulses", 32'((dv_cnt - n0) + (pe_cnt - p0) + (se_cnt - s0)), 32'd0);
    send_frame(8'h81, 6'd8, 0, 0, 0, 1, 0, 0, -1);
    idle(3);
    check("81_p_data", 32'(P_DATA), 32'h81);

    // randomized frames: config, parity, stop errors, sample noise, mid-frame config churn
    for (int k = 0; k < 40; k++) begin
      logic [5:0] pres;
      int pick;
      pick = int'($urandom_range(3));
      case (pick)
        0: pres = 6'd8;
        1: pres = 6'd16;
        2: pres = 6'd32;
        default: begin
          pres = 6'($urandom);
          while (pres == 6'd8 || pres == 6'd16 || pres == 6'd32) pres = 6'($urandom);
        end
      endcase
      send_frame(8'($urandom), pres, 1'($urandom), 1'($urandom),
                 ($urandom_range(3) == 0), ($urandom_range(4) != 0),
                 1'($urandom), 1'($urandom), -1);
      idle(int'($urandom_range(3)));
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter OP_WIDTH, default 8, giving the frame data width in bits.
REQ-002 The block SHALL have port CLK  input  1  oversampling clock; all state advances on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port RX_IN  input  1  serial line, idle high, already synchronised to CLK.
REQ-005 The block SHALL have port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 The block SHALL have port PAR_EN  input  1  parity bit present when 1.
REQ-007 The block SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 The block SHALL have port P_DATA  output  OP_WIDTH  last good received word.
REQ-009 The block SHALL have port data_valid  output  1  one-cycle pulse marking a new, error-free P_DATA.
REQ-010 The block SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 The block SHALL have port stp_err  output  1  one-cycle pulse on stop bit sampled low.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE -> START SHALL occur on the first cycle RX_IN is sampled 0; the edge counter SHALL start at 0 on that cycle.
REQ-014 Every bit SHALL last Prescale CLK cycles, tracked by an edge counter 0..Prescale-1 and a bit counter.
REQ-015 Each bit value SHALL be the majority of RX_IN at edge counts Prescale/2-1, Prescale/2, Prescale/2+1.
REQ-016 Prescale values other than 8, 16, 32 SHALL be treated as 8.
REQ-017 Prescale, PAR_EN and PAR_TYP SHALL be latched on IDLE -> START; later changes SHALL NOT affect the current frame.
REQ-018 DATA SHALL receive OP_WIDTH bits LSB first into a shift register, then go to PARITY if PAR_EN, else to STOP.
REQ-019 PARITY SHALL compare the sampled bit with XOR of the data bits (inverted when PAR_TYP=1).
REQ-020 On mismatch, par_err SHALL pulse for one cycle at the last edge count of the parity bit, and the frame SHALL be discarded.
REQ-021 STOP SHALL sample the stop bit; if 0, stp_err SHALL pulse for one cycle at the last edge count of the stop bit.
REQ-022 At the last edge count of STOP with no error, P_DATA SHALL load the word and data_valid SHALL pulse for exactly one cycle.
REQ-023 P_DATA SHALL hold its value until the next error-free frame completes.
REQ-024 The FSM SHALL return to IDLE after STOP, so a start bit on the next cycle is accepted (back-to-back frames).
REQ-025 par_err and stp_err SHALL be able to pulse in the same frame; data_valid SHALL NOT pulse in a frame with any error.

Reset
REQ-026 When RST=0, the block SHALL asynchronously force IDLE, clear both counters and the shift register, and drive P_DATA=0, data_valid=0, par_err=0, stp_err=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no pulse on any output; after release the block SHALL wait for a new falling edge.

Configuration
REQ-028 With macro UART_RX_STRT_CHK_EN defined, a start bit sampled 1 SHALL return the FSM to IDLE at its last edge count (glitch rejection) with no output pulse.
REQ-029 With UART_RX_STRT_CHK_EN undefined, the START sample SHALL be ignored and the FSM SHALL always proceed to DATA.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the legal Prescale constants (8, 16, 32) and the OP_WIDTH default.
REQ-031 Edge and bit counting SHALL live in one sub-module, edge_bit_counter, instantiated by uart_rx.

Verification
REQ-032 Prescale=8, PAR_EN=0, send 0xA5 -> P_DATA=0xA5, one data_valid pulse, no error pulses.
REQ-033 Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid; repeat with parity 1 -> par_err pulse only, P_DATA stays 0x3C.
REQ-034 Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x01 with stop bit 0 -> stp_err pulse, no data_valid.
REQ-035 With UART_RX_STRT_CHK_EN defined, a 2-cycle low glitch at Prescale=16 -> FSM back in IDLE, no output pulse; then 0x5A -> data_valid.
REQ-036 Two back-to-back frames 0xFF then 0x00 at Prescale=8 -> two data_valid pulses exactly 10*8 cycles apart.
REQ-037 RST asserted in DATA bit 4 of a frame -> all outputs 0, no pulse; the next full frame 0x81 -> data_valid, P_DATA=0x81.
